// File: rtl/imem_loader.sv
// Boot loader: turns a length-prefixed byte stream into big-endian instruction words
// written to consecutive imem word addresses, holding the core in reset until the image is complete.
`timescale 1ns/1ps
module imem_loader #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_BYTE, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t      r_state, w_next;
  logic [15:0] r_n;
  logic [15:0] r_words;
  logic [31:0] r_word;
  logic [1:0]  r_bcnt;
  logic        w_xfer;
  logic [15:0] w_hdr;

  assign w_xfer = rx_valid & rx_ready;
  assign w_hdr  = {r_n[15:8], rx_data};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start) w_next = S_HDR_HI;
      S_HDR_HI:              if (w_xfer) w_next = S_HDR_LO;
      S_HDR_LO: begin
        if (w_xfer) begin
          if (w_hdr > 16'(DEPTH))  w_next = S_ERR;
          else if (w_hdr == 16'd0) w_next = S_DONE;
          else                     w_next = S_BYTE;
        end
      end
      S_BYTE:  if (w_xfer && (r_bcnt == 2'd3)) w_next = S_WRITE;
      S_WRITE: w_next = ((r_words + 16'd1) == r_n) ? S_DONE : S_BYTE;
      default: w_next = S_IDLE;
    endcase
  end

  // Reset also clears the data registers so a load aborted by rst leaves no stale word behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_n     <= 16'd0;
      r_words <= 16'd0;
      r_word  <= 32'd0;
      r_bcnt  <= 2'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: if (start) r_words <= 16'd0;
        S_HDR_HI: if (w_xfer) r_n[15:8] <= rx_data;
        S_HDR_LO: begin
          if (w_xfer) r_n[7:0] <= rx_data;
          r_bcnt <= 2'd0;
        end
        S_BYTE: begin
          if (w_xfer) begin
            r_word <= {r_word[23:0], rx_data};
            r_bcnt <= r_bcnt + 2'd1;
          end
        end
        S_WRITE: r_words <= r_words + 16'd1;
        default: ;
      endcase
    end
  end

  // Every output is a decode of state or a register, so rx_valid/start never reach an output.
  assign rx_ready     = (r_state == S_HDR_HI) || (r_state == S_HDR_LO) || (r_state == S_BYTE);
  assign imem_we      = (r_state == S_WRITE);
  assign imem_addr    = {14'd0, r_words, 2'b00};
  assign imem_wdata   = r_word;
  assign cpu_rst      = (r_state != S_DONE);
  assign busy         = rx_ready || imem_we;
  assign done         = (r_state == S_DONE);
  assign err          = (r_state == S_ERR);
  assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a stream-level model predicts every memory write and the
// done latency; a per-cycle compare process checks the DUT against it.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, imem_we, cpu_rst, busy, done, err;
  logic [31:0] imem_addr, imem_wdata;
  logic [15:0] words_loaded;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int done_cyc  = -1;
  logic prev_done = 1'b0;

  logic [7:0]  stim[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Model: decode the stream as the format defines it and list the writes it must produce.
  function automatic int build_expected();
    int n;
    n = int'({stim[0], stim[1]});
    if (n > DEPTH) return n;
    for (int w = 0; w < n; w++) begin
      exp_addr_q.push_back(32'(4 * w));
      exp_data_q.push_back({stim[2+4*w], stim[3+4*w], stim[4+4*w], stim[5+4*w]});
    end
    return n;
  endfunction

  // Compare process: every write is checked against the model, plus per-cycle invariants.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      log_addr.push_back(imem_addr);
      log_data.push_back(imem_wdata);
      check("rx_ready_during_write", 32'(rx_ready), 32'h0);
      check("addr_align", 32'(imem_addr[1:0]), 32'h0);
      if (exp_addr_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, required no write", imem_addr, imem_wdata);
      end else begin
        check("write_addr", imem_addr, exp_addr_q.pop_front());
        check("write_data", imem_wdata, exp_data_q.pop_front());
      end
    end
    check("cpu_rst_vs_done", 32'(cpu_rst), 32'(!done));
    if (done && !prev_done) done_cyc = cyc;
    prev_done = done;
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start_cyc = cyc;
    done_cyc = -1;
  endtask

  task automatic send_stream(input bit gaps, input int nbytes);
    int idx = 0;
    int budget = 0;
    bit ph = 1'b0;
    bit take;
    while (idx < nbytes && budget < 2000) begin
      @(negedge clk);
      rx_valid = gaps ? ph : 1'b1;
      ph = ~ph;
      rx_data = stim[idx];
      take = rx_valid && rx_ready;
      @(posedge clk);
      if (take) idx++;
      budget++;
    end
    #1;
    rx_valid = 1'b0;
    if (idx < nbytes) begin
      n_assert++;
      n_fail++;
      $display("FAIL stream_timeout: accepted %0d bytes, required %0d", idx, nbytes);
    end
  endtask

  task automatic wait_status();
    int b = 0;
    while (b < 300) begin
      @(negedge clk);
      if (done || err) break;
      b++;
    end
    if (b >= 300) begin
      n_assert++;
      n_fail++;
      $display("FAIL status_timeout: done=%0b err=%0b, required one of them high", done, err);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    rst = 1'b1; start = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;

    // Reset with start and rx_valid active
    repeat (2) @(posedge clk);
    #1;
    check("rst_rx_ready", 32'(rx_ready), 32'h0);
    check("rst_imem_we", 32'(imem_we), 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_imem_wdata", imem_wdata, 32'h0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_words", 32'(words_loaded), 32'h0);
    rst = 1'b0; start = 1'b0; rx_valid = 1'b0;
    repeat (2) @(posedge clk);

    // Two-word load, rx_valid constant
    stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h40, 8'h20};
    n = build_expected();
    base = log_addr.size();
    pulse_start();
    #1;
    check("start_rx_ready", 32'(rx_ready), 32'h1);
    check("start_busy", 32'(busy), 32'h1);
    send_stream(1'b0, 10);
    wait_status();
    check("two_done", 32'(done), 32'h1);
    check("two_cpu_rst", 32'(cpu_rst), 32'h0);
    check("two_err", 32'(err), 32'h0);
    check("two_words", 32'(words_loaded), 32'd2);
    check("two_latency_model", 32'(done_cyc - start_cyc + 1), 32'(2 + 5 * n + 1));
    check("two_latency_lit", 32'(done_cyc - start_cyc + 1), 32'd13);
    check("two_pending", 32'(exp_addr_q.size()), 32'h0);
    check("two_count", 32'(log_addr.size() - base), 32'd2);
    if (log_addr.size() >= base + 2) begin
      check("two_w0_addr_lit", log_addr[base], 32'h0);
      check("two_w0_data_lit", log_data[base], 32'h20080005);
      check("two_w1_addr_lit", log_addr[base+1], 32'h4);
      check("two_w1_data_lit", log_data[base+1], 32'h01094020);
    end

    // Same image with rx_valid low every other cycle
    n = build_expected();
    base = log_addr.size();
    pulse_start();
    send_stream(1'b1, 10);
    wait_status();
    check("bp_done", 32'(done), 32'h1);
    check("bp_words", 32'(words_loaded), 32'd2);
    check("bp_pending", 32'(exp_addr_q.size()), 32'h0);
    check("bp_count", 32'(log_addr.size() - base), 32'd2);

    // Empty image
    stim = '{8'h00, 8'h00};
    n = build_expected();
    base = log_addr.size();
    pulse_start();
    send_stream(1'b0, 2);
    wait_status();
    check("empty_done", 32'(done), 32'h1);
    check("empty_cpu_rst", 32'(cpu_rst), 32'h0);
    check("empty_latency_model", 32'(done_cyc - start_cyc + 1), 32'(2 + 5 * n + 1));
    check("empty_latency_lit", 32'(done_cyc - start_cyc + 1), 32'd3);
    check("empty_count", 32'(log_addr.size() - base), 32'h0);
    check("empty_words", 32'(words_loaded), 32'h0);

    // Oversize image (DEPTH+1), then a valid one-word image
    stim = '{8'h00, 8'h41};
    n = build_expected();
    base = log_addr.size();
    pulse_start();
    send_stream(1'b0, 2);
    wait_status();
    check("over_err", 32'(err), 32'h1);
    check("over_cpu_rst", 32'(cpu_rst), 32'h1);
    check("over_rx_ready", 32'(rx_ready), 32'h0);
    check("over_done", 32'(done), 32'h0);
    check("over_busy", 32'(busy), 32'h0);
    check("over_count", 32'(log_addr.size() - base), 32'h0);
    stim = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    n = build_expected();
    pulse_start();
    #1;
    check("over_restart_err", 32'(err), 32'h0);
    send_stream(1'b0, 6);
    wait_status();
    check("recover_done", 32'(done), 32'h1);
    check("recover_err", 32'(err), 32'h0);
    check("recover_words", 32'(words_loaded), 32'd1);
    check("recover_pending", 32'(exp_addr_q.size()), 32'h0);

    // Reset after the 2nd byte of word 1, then a fresh one-word image
    stim = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    base = log_addr.size();
    pulse_start();
    send_stream(1'b0, 4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_cpu_rst", 32'(cpu_rst), 32'h1);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_rx_ready", 32'(rx_ready), 32'h0);
    check("midrst_words", 32'(words_loaded), 32'h0);
    check("midrst_wdata", imem_wdata, 32'h0);
    repeat (3) @(posedge clk);
    check("midrst_count", 32'(log_addr.size() - base), 32'h0);
    n = build_expected();
    pulse_start();
    send_stream(1'b0, 6);
    wait_status();
    check("fresh_done", 32'(done), 32'h1);
    check("fresh_count", 32'(log_addr.size() - base), 32'd1);
    if (log_addr.size() == base + 1) begin
      check("fresh_addr_lit", log_addr[base], 32'h0);
      check("fresh_data_lit", log_data[base], 32'hAABBCCDD);
    end
    check("fresh_pending", 32'(exp_addr_q.size()), 32'h0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the MIPS core's instruction memory. It receives a byte stream over a valid/ready interface, assembles big-endian 32-bit instruction words, and writes them to consecutive instruction-memory word addresses. It holds the core in reset until the image is complete, so the PC starts at 0 only once a valid program is resident.

## Interface
- DEPTH, 64: instruction-memory capacity in words; a larger image is rejected.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- rx_data  in  8  incoming stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle; a transfer occurs when rx_valid & rx_ready at the rising edge.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  32  byte address, word index × 4, so bits [1:0] are always 0.
- imem_wdata  out  32  assembled instruction word.
- cpu_rst  out  1  reset to the core's PC and register file; high until a load completes.
- busy  out  1  load in progress.
- done  out  1  image loaded; core released.
- err  out  1  image rejected.
- words_loaded  out  16  count of words written in the current load.

## Operation
- Stream format: 16-bit word count N, high byte first, then 4·N instruction bytes, each word MSB first.
- States: IDLE, HDR_HI, HDR_LO, BYTE, WRITE, DONE, ERR.
- IDLE: on start → HDR_HI; clear words_loaded and the word address.
- HDR_HI: rx_ready=1; on transfer latch N[15:8] → HDR_LO.
- HDR_LO: rx_ready=1; on transfer latch N[7:0], then:
  - N > DEPTH → ERR.
  - N = 0 → DONE.
  - Otherwise → BYTE with byte counter = 0.
- BYTE: rx_ready=1; on each transfer shift the byte into the word register (first byte lands in [31:24]). On the 4th byte → WRITE.
- WRITE: rx_ready=0; imem_we=1 with imem_addr = 4·words_loaded and imem_wdata = assembled word. At the edge, words_loaded increments, then:
  - words_loaded+1 = N → DONE.
  - Otherwise → BYTE.
- DONE: cpu_rst=0, done=1; start → HDR_HI, re-asserting cpu_rst and clearing done and words_loaded.
- ERR: err=1, cpu_rst=1; no memory writes; start → HDR_HI, clearing err.
- busy=1 in HDR_HI, HDR_LO, BYTE and WRITE; start is ignored while busy.
- Bytes presented in IDLE, DONE or ERR are not accepted (rx_ready=0).

## Timing
- All outputs are registered or decoded from state only; there are no combinational paths from rx_valid or start to any output.
- Reset values: rx_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_rst 1, busy 0, done 0, err 0, words_loaded 0; state IDLE.
- Start sampled at edge k → rx_ready=1 from cycle k+1.
- Word latency: imem_we is high in the cycle after the edge that accepts the 4th byte.
- With rx_valid held high:
  - header takes 2 cycles, each word takes 5 cycles;
  - done rises in the cycle after the last WRITE;
  - total from start edge to done = 2 + 5N + 1 cycles.
- cpu_rst falls in the same cycle done rises.
- rx_valid gaps stall the state machine indefinitely with no timeout; partial-word contents are held.
- rst mid-load (any state) discards the partial word, performs no write, returns to IDLE and re-asserts cpu_rst. rst has priority over start and rx transfers in the same cycle.
- N = DEPTH is legal: the last write goes to address 4·(DEPTH−1). words_loaded never exceeds N.

## Test plan
- Reset: assert rst 2 cycles with rx_valid=1 and start=1 → all outputs at reset values; no imem_we.
- Two-word load, rx_valid constant: start, then bytes 00 02 20 08 00 05 01 09 40 20 →
  - imem_we at addr 0 with 0x20080005, then at addr 4 with 0x01094020;
  - words_loaded=2; done and cpu_rst=0 exactly 13 cycles after the start edge.
- Back-pressure: same image with rx_valid low every other cycle → identical writes and values; rx_ready=0 during each WRITE cycle; no byte lost or duplicated.
- Empty image: bytes 00 00 → done=1 and cpu_rst=0 after 3 cycles; imem_we never asserted.
- Oversize image: header equal to DEPTH+1 (0x0041 for DEPTH=64) → err=1, cpu_rst=1, rx_ready=0, no writes. A subsequent start with a valid one-word image → done, err=0.
- Reset mid-load: rst after the 2nd byte of word 1 → IDLE, cpu_rst=1, no imem_we. A fresh start with a one-word image 0xAABBCCDD → single write at addr 0 with 0xAABBCCDD.
